bias_loader: RTL and testbench
==============================

# bias_loader

Synthesizable initiator for the byte-serial `readM`/`ready` bias-memory handshake. On `start` it fetches `NUM_BIAS` consecutive bytes from the bias memory, one four-phase handshake per byte. Each byte is presented on a single-cycle write port into the LSTM bias register file. It sits between the off-chip or testbench bias memory and the LSTM datapath, and has sole control of `readM`.

## Interface
- `NUM_BIAS`, default 32: number of bytes fetched per load; must be at least 1.
- `ADDR_WIDTH`, default 5: width of `bias_addr`; must satisfy 2^ADDR_WIDTH >= NUM_BIAS.
- `TIMEOUT`, default 1023: maximum number of cycles to wait on either edge of `ready` before aborting.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- `readM`  out  1  read request to the bias memory.
- `ready`  in  1  responder acknowledge; asynchronous to `clk`.
- `data`  in  8  responder byte; stable whenever `ready` is high.
- `bias_we`  out  1  one-cycle write strobe.
- `bias_addr`  out  ADDR_WIDTH  index of the byte being fetched or written.
- `bias_data`  out  8  captured byte; valid while `bias_we` is high.
- `busy`  out  1  high while in REQ or REL.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.

## Operation
- `ready` passes through a 2-flop synchronizer to form `rdy_s`. `data` is not synchronized; it is captured only when `rdy_s` is 1.
- FSM states: IDLE, REQ, REL, DONE, ERR.
- IDLE, DONE and ERR:
  - On `start`: clear `bias_addr`, clear the timeout counter, go to REQ.
  - `done` and `error` clear when REQ is entered.
- REQ:
  - `readM` is 1.
  - When `rdy_s` is 1: latch `data` into `bias_data`, pulse `bias_we` for the next cycle, drive `readM` to 0 on that same edge, and go to REL.
- REL:
  - `readM` is 0.
  - When `rdy_s` is 0 and `bias_addr` equals NUM_BIAS-1: go to DONE.
  - When `rdy_s` is 0 otherwise: increment `bias_addr` and go to REQ.
- Timeout:
  - A counter clears on every entry to REQ or REL and increments each cycle spent waiting.
  - When it reaches TIMEOUT: go to ERR with `readM` at 0. `bias_addr` holds the failing index.
- `start` is ignored in REQ and REL. It is accepted in DONE and ERR, which restarts from address 0.
- `bias_addr` never wraps. The final value is NUM_BIAS-1, held in DONE.
- Reset values:
  - State is IDLE.
  - `readM`, `bias_we`, `busy`, `done`, `error` are 0.
  - `bias_addr` and `bias_data` are 0.
  - Synchronizer flops and timeout counter are 0.
- Reset during REQ or REL: the next edge forces IDLE and `readM` to 0. No `bias_we` is issued for a byte in flight. The responder's address pointer is the bench's responsibility.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: `readM` = 1 and `busy` = 1.
- `ready` rising at edge k makes `rdy_s` = 1 after edge k+2. The next edge then sets `bias_we` = 1 with `readM` = 0. `bias_we` is high for exactly one cycle.
- `ready` falling at edge m makes `rdy_s` = 0 after edge m+2. The next edge asserts `readM` for the following byte, or enters DONE.
- With a zero-delay responder, each byte takes 6 cycles; the load takes 6×NUM_BIAS + 1 cycles from `start` to `done`.
- `readM` never rises while `rdy_s` is 1, and never falls while `rdy_s` is 0 in REQ.
- `done` and `error` are levels. They are never both 1, and neither is 1 together with `busy`.

## Test plan
- Full load: responder holds 32 bytes of 0x80, `start` pulsed once. Expect exactly 32 `bias_we` pulses, addresses 0..31 in order, `bias_data` = 0x80 on each, then `done` = 1, `busy` = 0, `readM` = 0.
- Pattern and latency: memory[i] = i XOR 0xA5, responder delay 0 cycles, then 7 cycles. Every write address/data pair matches. Delay-0 run reaches `done` in 193 cycles. Handshake ordering holds throughout.
- Timeout: responder never raises `ready` after byte 5. Expect `error` = 1 exactly TIMEOUT cycles after REQ entry, `bias_addr` = 5, `readM` = 0, no 6th write. A second `start` then completes a full load.
- Reset mid-transfer: assert `rst` while in REQ for byte 10. Expect `readM` = 0, all outputs at reset values on the next edge, and no further `bias_we`.
- `start` while busy: pulse `start` during byte 3. Expect the sequence unchanged and 32 writes total. `start` in DONE restarts from address 0.
- Glitch-free stretch: hold `ready` high for 20 cycles. Expect a single `bias_we` for that byte and `readM` held at 0 until `ready` has been low for 2 synchronizer cycles.

Source files
------------

// File: rtl/bias_loader_if.sv
// Byte-serial bias-memory handshake bundle: control/status plus the readM/ready/data
// link and the single-cycle write port into the LSTM bias register file.
interface bias_loader_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  readM;
  logic                  ready;
  logic [7:0]            data;
  logic                  bias_we;
  logic [ADDR_WIDTH-1:0] bias_addr;
  logic [7:0]            bias_data;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, ready, data,
    output readM, bias_we, bias_addr, bias_data, busy, done, error
  );

  modport slave (
    output start, ready, data,
    input  readM, bias_we, bias_addr, bias_data, busy, done, error
  );
endinterface

// File: rtl/bias_loader.sv
// Fetches NUM_BIAS bytes over a four-phase readM/ready handshake and writes each one
// into the bias register file; aborts to ERR if either ready edge takes TIMEOUT cycles.
module bias_loader #(
  parameter int NUM_BIAS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 1023
) (
  input logic           clk,
  input logic           rst,
  bias_loader_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] REL  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BIAS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [2:0]            state;
  logic                  sync1;
  logic                  rdy_s;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data_q;
  logic                  we;

  // NOTE: every register here is assigned with <= so all flops sample the same
  // pre-edge values; blocking assignments would make the synchronizer collapse
  // into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sync1  <= 1'b0;
      rdy_s  <= 1'b0;
      cnt    <= '0;
      addr   <= '0;
      data_q <= '0;
      we     <= 1'b0;
    end else begin
      sync1 <= bus.ready;
      rdy_s <= sync1;
      we    <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            addr  <= '0;
            cnt   <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          // data is safe to sample unsynchronized: it is stable whenever ready is high
          if (rdy_s) begin
            data_q <= bus.data;
            we     <= 1'b1;
            cnt    <= '0;
            state  <= REL;
          end else if (cnt == CNT_LAST) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          if (!rdy_s) begin
            cnt <= '0;
            if (addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= REQ;
            end
          end else if (cnt == CNT_LAST) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and readM decode straight from the state register, so they change
  // only on clock edges and drop together with the state on reset.
  assign bus.readM     = (state == REQ);
  assign bus.busy      = (state == REQ) || (state == REL);
  assign bus.done      = (state == DONE);
  assign bus.error     = (state == ERR);
  assign bus.bias_we   = we;
  assign bus.bias_addr = addr;
  assign bus.bias_data = data_q;

endmodule

// File: tb/tb_bias_loader.sv
// Randomized scoreboard bench for bias_loader: a cycle-level responder model serves
// bytes from a memory array, and a monitor checks every write against queued expectations.
module tb_bias_loader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_loader_if #(.ADDR_WIDTH(AW)) bus ();

  bias_loader #(
    .NUM_BIAS  (N),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] mem [N];
  int         n_writes = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  // Responder model: a small per-cycle behaviour acting 2 time units after each edge.
  int resp_delay = 0;
  bit rand_delay = 1'b0;
  int stall_idx  = -1;
  int hold_idx   = -1;
  int hold_len   = 0;
  bit resp_reset = 1'b0;
  int ptr = 0, phase = 0, rcnt = 0, cur_delay = 0;

  always begin
    @(posedge clk);
    #2;
    if (resp_reset) begin
      bus.ready = 1'b0;
      ptr = 0;
      phase = 0;
      rcnt = 0;
    end else begin
      case (phase)
        0: if (bus.readM) begin
          cur_delay = rand_delay ? int'($urandom_range(0, 3)) : resp_delay;
          if (ptr == stall_idx) phase = 3;
          else if (cur_delay == 0) begin
            bus.data = mem[ptr % N]; bus.ready = 1'b1; phase = 2;
          end else begin
            rcnt = 1; phase = 1;
          end
        end
        1: if (rcnt >= cur_delay) begin
          bus.data = mem[ptr % N]; bus.ready = 1'b1; phase = 2;
        end else rcnt++;
        2: if (!bus.readM) begin
          if (ptr == hold_idx && hold_len > 0) begin
            rcnt = 1; phase = 4;
          end else begin
            bus.ready = 1'b0; ptr++; phase = 0;
          end
        end
        4: if (rcnt >= hold_len) begin
          bus.ready = 1'b0; ptr++; phase = 0;
        end else rcnt++;
        default: ;
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every write.
  logic prev_we = 1'b0;
  logic prev_rm = 1'b0;
  int   low_cnt = 100;

  always @(negedge clk) begin
    if (bus.bias_we) begin
      n_writes++;
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", bus.bias_addr, bus.bias_data);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(bus.bias_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.bias_data), 32'(mon_e.data));
      end
    end
    // ready low at edge m is seen by rdy_s after m+2, so readM may rise no earlier than m+3
    if (bus.readM && !prev_rm)
      check("readM_rise_after_ready_low_3", 32'(low_cnt >= 3), 32'd1);
    if (bus.done || bus.error)
      check("status_exclusive", {30'd0, bus.busy, bus.done & bus.error}, 32'd0);
    low_cnt = bus.ready ? 0 : low_cnt + 1;
    prev_we = bus.bias_we;
    prev_rm = bus.readM;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp_clear();
    resp_reset = 1'b1;
    step();
    resp_reset = 1'b0;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{addr: AW'(i), data: mem[i]});
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_load(input int max, output int cyc_n);
    bus.start = 1'b1;
    cyc_n = 0;
    do begin
      step();
      bus.start = 1'b0;
      cyc_n++;
    end while (!(bus.done || bus.error) && cyc_n < max);
    check("load_finished", 32'(bus.done | bus.error), 32'd1);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!(bus.done || bus.error) && k < max) begin step(); k++; end
    check("load_finished", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_byte_req(input int a, input int max, input string tag);
    int k = 0;
    while (!(32'(bus.bias_addr) == a && bus.readM) && k < max) begin step(); k++; end
    check(tag, 32'(bus.bias_addr == AW'(a) && bus.readM), 32'd1);
  endtask

  task automatic check_done_state();
    check("done_level", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_readM", 32'(bus.readM), 32'd0);
    check("done_error", 32'(bus.error), 32'd0);
    check("done_addr", 32'(bus.bias_addr), 32'(N - 1));
  endtask

  task automatic check_writes(input int exp_n);
    check("write_count", 32'(n_writes), 32'(exp_n));
    check("sb_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_readM", 32'(bus.readM), 32'd0);
    check("rst_bias_we", 32'(bus.bias_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_bias_addr", 32'(bus.bias_addr), 32'd0);
    check("rst_bias_data", 32'(bus.bias_data), 32'd0);
  endtask

  int lat;
  int t0, t1;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ready = 1'b0;
    bus.data  = 8'h00;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Full load of constant bytes
    for (int i = 0; i < N; i++) mem[i] = 8'h80;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    run_load(400, lat);
    check_done_state();
    check_writes(N);

    // Pattern with zero-delay responder: 6 cycles per byte plus the start cycle
    for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'hA5;
    resp_delay = 0;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    run_load(400, lat);
    check("latency_delay0", 32'(lat), 32'(6 * N + 1));
    check_done_state();
    check_writes(N);

    // Same pattern, responder answering 7 cycles late, restarting from DONE
    resp_delay = 7;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    run_load(800, lat);
    check("latency_delay7", 32'(lat), 32'((6 + 7) * N + 1));
    check_done_state();
    check_writes(N);

    // start pulsed mid-load is ignored; random data and random responder delays
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    resp_delay = 0;
    rand_delay = 1'b1;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    pulse_start();
    wait_byte_req(3, 200, "reach_byte3");
    pulse_start();
    wait_done(600);
    check_done_state();
    check_writes(N);
    rand_delay = 1'b0;

    // Timeout: responder never answers byte 5
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    stall_idx = 5;
    resp_clear();
    n_writes = 0;
    push_exp(5);
    pulse_start();
    wait_byte_req(5, 200, "reach_byte5");
    t0 = cyc;
    t1 = 0;
    for (int k = 0; k < TO + 20 && !bus.error; k++) step();
    t1 = cyc;
    check("error_level", 32'(bus.error), 32'd1);
    check("timeout_cycles", 32'(t1 - t0), 32'(TO));
    check("err_addr", 32'(bus.bias_addr), 32'd5);
    check("err_readM", 32'(bus.readM), 32'd0);
    check("err_busy", 32'(bus.busy), 32'd0);
    check("err_done", 32'(bus.done), 32'd0);
    check_writes(5);

    stall_idx = -1;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    run_load(400, lat);
    check_done_state();
    check_writes(N);

    // ready stretched high for byte 2: a single write, readM held until the release is seen
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    hold_idx = 2;
    hold_len = 20;
    resp_clear();
    n_writes = 0;
    push_exp(N);
    run_load(600, lat);
    check_done_state();
    check_writes(N);
    hold_idx = -1;
    hold_len = 0;

    // Reset while REQ for byte 10 is outstanding
    for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'hA5;
    resp_clear();
    n_writes = 0;
    push_exp(10);
    pulse_start();
    wait_byte_req(10, 200, "reach_byte10");
    rst = 1'b1;
    step();
    check_reset_outputs();
    resp_reset = 1'b1;
    step();
    resp_reset = 1'b0;
    step();
    rst = 1'b0;
    repeat (20) step();
    check_writes(10);
    check("post_rst_readM", 32'(bus.readM), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
